pipe_ctrl_chain: RTL
====================

Name: pipe_ctrl_chain

Overview:
- Parametrised control-signal pipeline that replaces the fixed ID/EX, EX/MEM and MEM/WB control registers with one N-stage chain.
- Adds what the fixed registers lack: per-stage valid bits, bubble insertion, load-use stall detection, branch flush, global hold and operand forwarding selects.
- Sits between the control unit/mux (ID) and the datapath stages; drives PC and IF/ID enables.

Parameters:
- CTRL_W, 16, width of the packed control word per stage (alu_op, S, load, RF_E, size, RW, B, BL, AM).
- NUM_STAGES, 3, number of stages after ID (0=EX, 1=MEM, 2=WB); legal 2..6.
- REG_W, 4, register-address width.
- PC_REG, 15, register number never forwarded (PC).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Hold  in  1  freeze entire chain (memory wait).
- Flush  in  1  branch taken resolved in EX; kill ID instruction.
- ID_valid  in  1  ID holds a real instruction.
- ID_ctrl  in  CTRL_W  control word from the control mux.
- ID_rd  in  REG_W  destination register.
- ID_rd_we  in  1  instruction writes ID_rd.
- ID_load  in  1  instruction is a load.
- ID_rn, ID_rm  in  REG_W  source registers.
- ID_use_rn, ID_use_rm  in  1  source actually read.
- Stage_ctrl  out  NUM_STAGES*CTRL_W  flat; stage k at [k*CTRL_W +: CTRL_W].
- Stage_valid  out  NUM_STAGES  per-stage valid.
- Stage_rd  out  NUM_STAGES*REG_W  per-stage destination.
- PC_enable  out  1  PC may advance.
- IF_ID_enable  out  1  IF/ID may load.
- IF_ID_flush  out  1  IF/ID must load a bubble.
- Fwd_rn, Fwd_rm  out  FWD_W=$clog2(NUM_STAGES+1)  forwarding source select.

Behaviour:
- Reset low: all stage valid, ctrl, rd, rd_we and load bits are 0. Derived outputs: PC_enable=1, IF_ID_enable=1, IF_ID_flush=0, Fwd=0.
- Each stage holds {valid, ctrl, rd, rd_we, load}.
- Latency: an ID entry appears at stage k output k+1 cycles after capture.
- Load-use hazard (combinational): stage 0 is valid & load & rd_we, and its rd equals a used ID source (ID_use_rn & rn match, or ID_use_rm & rm match), with ID_valid=1.
- Next-state priority, evaluated per cycle:
  - Hold=1: every stage keeps its value. PC_enable=0, IF_ID_enable=0, IF_ID_flush=0. Flush and hazard are ignored; the source keeps Flush asserted while EX is held.
  - Flush=1: stage 0 gets a bubble (valid=0, ctrl=0, rd_we=0, load=0); older stages shift. PC_enable=1, IF_ID_enable=1, IF_ID_flush=1. A pending hazard is discarded.
  - Hazard: stage 0 gets a bubble; older stages shift. PC_enable=0, IF_ID_enable=0, IF_ID_flush=0. Exactly one stall cycle per hazard.
  - Otherwise: stage 0 gets the ID fields, masked to a bubble when ID_valid=0; older stages shift.
- Last-stage contents drop off the end each shift.
- Forwarding, per operand:
  - Fwd = k+1 for the youngest stage k where Stage_valid & rd_we & rd == src & src != PC_REG & use bit.
  - Fwd = 0 when no stage matches.
  - Stage 0 loads are excluded from matching (the stall covers them).
- Reset asserted mid-operation clears all stages immediately (asynchronous); in-flight instructions are lost.

Optional Feature:
- PIPE_PERF_EN defined: adds outputs Stall_count[31:0] and Flush_count[31:0].
  - Stall_count increments on every hazard-stall cycle with Hold=0.
  - Flush_count increments on every Flush cycle with Hold=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - control-word field offsets (ALU_OP_LSB, S_BIT, LOAD_BIT, RF_E_BIT, SIZE_BIT, RW_BIT, B_BIT, BL_BIT, AM_LSB);
  - the BUBBLE constant;
  - the fwd_sel_t encoding (FWD_NONE=0).
- One sub-module, pipe_stage_reg: a single stage register with load/hold/bubble control, instantiated NUM_STAGES times by a generate loop.
- Hazard and forwarding logic stay in the top module.

Test Plan:
- Reset low, then high, with ID_valid=1, ID_ctrl=16'h1234: Stage_ctrl[0] reads 16'h1234 on the next edge, stage 2 two edges later, and Stage_valid walks 001→010→100.
- Load r3 in stage 0, then an ID instruction using rn=r3: one bubble enters stage 0. PC_enable=0 and IF_ID_enable=0 for exactly 1 cycle, then Fwd_rn=2 (MEM).
- Flush=1 with ID_valid=1: stage 0 becomes a bubble and IF_ID_flush=1 for 1 cycle. The older stages still shift.
- Hold=1 for 3 cycles with Flush=1 concurrently: all stages unchanged and PC_enable=0. The flush takes effect on the first cycle after Hold drops.
- r5 written in stage 0 (non-load) and in stage 2, ID rm=r5: Fwd_rm=1. For rm=r15 with the same stages writing r15: Fwd_rm=0.
- With PIPE_PERF_EN: 2 hazards and 1 flush give Stall_count=2 and Flush_count=1. Asserting Reset mid-run zeroes both counters and clears all stages.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the control-signal pipeline chain: control-word
// field offsets, the bubble word and the forwarding-select encoding.
package pipe_pkg;

    localparam int unsigned CTRL_W_DFLT = 16;

    // Control-word field layout (LSB positions / widths)
    localparam int unsigned ALU_OP_LSB = 0;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned S_BIT      = 4;
    localparam int unsigned LOAD_BIT   = 5;
    localparam int unsigned RF_E_BIT   = 6;
    localparam int unsigned SIZE_BIT   = 7;
    localparam int unsigned SIZE_W     = 2;
    localparam int unsigned RW_BIT     = 9;
    localparam int unsigned B_BIT      = 10;
    localparam int unsigned BL_BIT     = 11;
    localparam int unsigned AM_LSB     = 12;
    localparam int unsigned AM_W       = 2;

    // A bubble carries an all-zero control word (no side effects anywhere)
    localparam logic [CTRL_W_DFLT-1:0] BUBBLE = '0;

    // Forwarding select: 0 = register file, k+1 = result held in stage k
    localparam int unsigned FWD_SEL_W = 3;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_NONE = 3'd0,
        FWD_S0   = 3'd1,
        FWD_S1   = 3'd2,
        FWD_S2   = 3'd3,
        FWD_S3   = 3'd4,
        FWD_S4   = 3'd5,
        FWD_S5   = 3'd6
    } fwd_sel_t;

    // Map a stage index to its forwarding select code
    function automatic fwd_sel_t fwd_from_stage(input int k);
        return fwd_sel_t'(FWD_SEL_W'(k + 1));
    endfunction

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Bundle of ID-side inputs and chain outputs for pipe_ctrl_chain.
// master: control unit / testbench side; slave: the chain itself.
interface pipe_ctrl_chain_if #(
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_W      = 4
) ();
    localparam int unsigned FWD_W = $clog2(NUM_STAGES + 1);

    logic                           Hold;
    logic                           Flush;
    logic                           ID_valid;
    logic [CTRL_W-1:0]              ID_ctrl;
    logic [REG_W-1:0]               ID_rd;
    logic                           ID_rd_we;
    logic                           ID_load;
    logic [REG_W-1:0]               ID_rn;
    logic [REG_W-1:0]               ID_rm;
    logic                           ID_use_rn;
    logic                           ID_use_rm;

    logic [NUM_STAGES*CTRL_W-1:0]   Stage_ctrl;
    logic [NUM_STAGES-1:0]          Stage_valid;
    logic [NUM_STAGES*REG_W-1:0]    Stage_rd;
    logic                           PC_enable;
    logic                           IF_ID_enable;
    logic                           IF_ID_flush;
    logic [FWD_W-1:0]               Fwd_rn;
    logic [FWD_W-1:0]               Fwd_rm;

    modport master (
        output Hold, Flush, ID_valid, ID_ctrl, ID_rd, ID_rd_we, ID_load,
               ID_rn, ID_rm, ID_use_rn, ID_use_rm,
        input  Stage_ctrl, Stage_valid, Stage_rd, PC_enable, IF_ID_enable,
               IF_ID_flush, Fwd_rn, Fwd_rm
    );

    modport slave (
        input  Hold, Flush, ID_valid, ID_ctrl, ID_rd, ID_rd_we, ID_load,
               ID_rn, ID_rm, ID_use_rn, ID_use_rm,
        output Stage_ctrl, Stage_valid, Stage_rd, PC_enable, IF_ID_enable,
               IF_ID_flush, Fwd_rn, Fwd_rm
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One stage of the control chain: holds {valid, ctrl, rd, rd_we, load}.
// hold keeps the contents, bubble loads an all-zero entry, else loads nxt_*.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              bubble,
    input  logic              nxt_valid,
    input  logic [CTRL_W-1:0] nxt_ctrl,
    input  logic [REG_W-1:0]  nxt_rd,
    input  logic              nxt_rd_we,
    input  logic              nxt_load,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [REG_W-1:0]  rd,
    output logic              rd_we,
    output logic              load
);

    // Stage contents: clear on reset, freeze on hold, else bubble or load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            rd    <= '0;
            rd_we <= 1'b0;
            load  <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                valid <= 1'b0;
                ctrl  <= CTRL_W'(BUBBLE);
                rd    <= '0;
                rd_we <= 1'b0;
                load  <= 1'b0;
            end else begin
                valid <= nxt_valid;
                ctrl  <= nxt_ctrl;
                rd    <= nxt_rd;
                rd_we <= nxt_rd_we;
                load  <= nxt_load;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// N-stage control-signal pipeline (stage 0 = EX) with valid bits, bubble
// insertion, load-use stall, branch flush, global hold and forwarding selects.
// Optional build macro PIPE_PERF_EN adds Stall_count / Flush_count outputs.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned PC_REG     = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    pipe_ctrl_chain_if.slave bus
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0] Stall_count,
    output logic [31:0] Flush_count
`endif
);

    localparam int unsigned FWD_W = $clog2(NUM_STAGES + 1);

    logic              st_valid [NUM_STAGES];
    logic [CTRL_W-1:0] st_ctrl  [NUM_STAGES];
    logic [REG_W-1:0]  st_rd    [NUM_STAGES];
    logic              st_rd_we [NUM_STAGES];
    logic              st_load  [NUM_STAGES];

    logic     hazard;
    logic     stage0_bubble;
    fwd_sel_t fwd_rn_sel;
    fwd_sel_t fwd_rm_sel;

    logic [NUM_STAGES*CTRL_W-1:0] ctrl_flat;
    logic [NUM_STAGES*REG_W-1:0]  rd_flat;
    logic [NUM_STAGES-1:0]        valid_flat;

    // Load in EX whose result an ID source needs: stall ID for one cycle
    always_comb begin
        hazard = st_valid[0] & st_load[0] & st_rd_we[0] & bus.ID_valid &
                 ((bus.ID_use_rn & (bus.ID_rn == st_rd[0])) |
                  (bus.ID_use_rm & (bus.ID_rm == st_rd[0])));
    end

    assign stage0_bubble = bus.Flush | hazard | ~bus.ID_valid;

    // Stage registers: stage 0 is fed from ID, each later stage from its predecessor
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage_reg #(.CTRL_W(CTRL_W), .REG_W(REG_W)) u_stage (
                .clk       (Clk),
                .rst_n     (Reset),
                .hold      (bus.Hold),
                .bubble    (stage0_bubble),
                .nxt_valid (bus.ID_valid),
                .nxt_ctrl  (bus.ID_ctrl),
                .nxt_rd    (bus.ID_rd),
                .nxt_rd_we (bus.ID_rd_we),
                .nxt_load  (bus.ID_load),
                .valid     (st_valid[k]),
                .ctrl      (st_ctrl[k]),
                .rd        (st_rd[k]),
                .rd_we     (st_rd_we[k]),
                .load      (st_load[k])
            );
        end else begin : g_body
            pipe_stage_reg #(.CTRL_W(CTRL_W), .REG_W(REG_W)) u_stage (
                .clk       (Clk),
                .rst_n     (Reset),
                .hold      (bus.Hold),
                .bubble    (1'b0),
                .nxt_valid (st_valid[k-1]),
                .nxt_ctrl  (st_ctrl[k-1]),
                .nxt_rd    (st_rd[k-1]),
                .nxt_rd_we (st_rd_we[k-1]),
                .nxt_load  (st_load[k-1]),
                .valid     (st_valid[k]),
                .ctrl      (st_ctrl[k]),
                .rd        (st_rd[k]),
                .rd_we     (st_rd_we[k]),
                .load      (st_load[k])
            );
        end
    end

    // Flatten per-stage contents onto the output buses
    always_comb begin
        ctrl_flat  = '0;
        rd_flat    = '0;
        valid_flat = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            ctrl_flat[k*CTRL_W +: CTRL_W] = st_ctrl[k];
            rd_flat[k*REG_W +: REG_W]     = st_rd[k];
            valid_flat[k]                 = st_valid[k];
        end
    end

    // Forwarding selects: scan oldest to youngest so the youngest match wins;
    // a load still in stage 0 is skipped because the stall covers it
    always_comb begin
        fwd_rn_sel = FWD_NONE;
        fwd_rm_sel = FWD_NONE;
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            if (st_valid[k] && st_rd_we[k] && !((k == 0) && st_load[k])) begin
                if (bus.ID_use_rn && (bus.ID_rn != REG_W'(PC_REG)) &&
                    (st_rd[k] == bus.ID_rn)) begin
                    fwd_rn_sel = fwd_from_stage(k);
                end
                if (bus.ID_use_rm && (bus.ID_rm != REG_W'(PC_REG)) &&
                    (st_rd[k] == bus.ID_rm)) begin
                    fwd_rm_sel = fwd_from_stage(k);
                end
            end
        end
    end

    assign bus.Stage_ctrl   = ctrl_flat;
    assign bus.Stage_rd     = rd_flat;
    assign bus.Stage_valid  = valid_flat;
    assign bus.Fwd_rn       = FWD_W'(fwd_rn_sel);
    assign bus.Fwd_rm       = FWD_W'(fwd_rm_sel);
    // Front-end enables: hold freezes everything, flush overrides a stall
    assign bus.PC_enable    = ~bus.Hold & (bus.Flush | ~hazard);
    assign bus.IF_ID_enable = ~bus.Hold & (bus.Flush | ~hazard);
    assign bus.IF_ID_flush  = ~bus.Hold & bus.Flush;

`ifdef PIPE_PERF_EN
    // Event counters: flush cycles and genuine (non-flushed) stall cycles
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Stall_count <= '0;
            Flush_count <= '0;
        end else if (!bus.Hold) begin
            if (bus.Flush) begin
                Flush_count <= Flush_count + 32'd1;
            end else if (hazard) begin
                Stall_count <= Stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
